// File: rtl/key_pkg.sv
// Shared PS/2 set-2 constants and prefix-FSM state type for the keyboard entry path.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kstate_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Index in this table is the nibble value; entries 10..15 are the A-F keys.
  localparam logic [7:0] SC_DIGIT [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

endpackage

// File: rtl/scan_decode.sv
// Combinational set-2 make code to hex nibble lookup.
module scan_decode
  import key_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic [3:0] nibble,
  output logic       is_digit,
  output logic       is_hex
);

  always_comb begin
    nibble   = '0;
    is_digit = 1'b0;
    is_hex   = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (scan_code == SC_DIGIT[i]) begin
        nibble   = 4'(i);
        is_digit = 1'b1;
        is_hex   = (i >= 10);
      end
    end
  end

endmodule

// File: rtl/key_entry.sv
// Hex keypad entry from PS/2 scan codes: digit buffer for the display, committed value on enter.
module key_entry
  import key_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 8,
  parameter bit          HEX_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  scan_code,
  input  logic        scan_valid,
  output logic [31:0] temp_data,
  output logic [31:0] reg_data,
  output logic        enter,
  output logic        key_pressed,
  output logic [3:0]  digit_cnt,
  output logic        overflow
);

  kstate_t    state;
  logic [3:0] nibble;
  logic       is_digit;
  logic       is_hex;
  logic       idle_make;
  logic       do_digit;
  logic       do_bksp;
  logic       do_esc;
  logic       do_commit;
  logic       buf_full;

  scan_decode u_decode (
    .scan_code (scan_code),
    .nibble    (nibble),
    .is_digit  (is_digit),
    .is_hex    (is_hex)
  );

  // Action decode is split out so plain and extended enter share one commit path.
  always_comb begin
    idle_make = scan_valid && (state == ST_IDLE) &&
                (scan_code != SC_BREAK) && (scan_code != SC_EXT);
    do_digit  = idle_make && is_digit && (HEX_EN || !is_hex);
    do_bksp   = idle_make && (scan_code == SC_BKSP);
    do_esc    = idle_make && (scan_code == SC_ESC);
    do_commit = (scan_code == SC_ENTER) &&
                (idle_make || (scan_valid && (state == ST_EXT)));
    buf_full  = (digit_cnt == 4'(MAX_DIGITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      temp_data   <= '0;
      reg_data    <= '0;
      digit_cnt   <= '0;
      overflow    <= 1'b0;
      enter       <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      enter       <= 1'b0;
      key_pressed <= do_digit || do_bksp || do_esc || do_commit;

      if (scan_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (scan_code == SC_BREAK)    state <= ST_BRK;
            else if (scan_code == SC_EXT) state <= ST_EXT;
          end
          ST_EXT:     state <= (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
          ST_BRK,
          ST_EXT_BRK: state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end

      if (do_commit) begin
        reg_data  <= temp_data;
        temp_data <= '0;
        digit_cnt <= '0;
        overflow  <= 1'b0;
        enter     <= 1'b1;
      end else if (do_digit) begin
        if (buf_full) begin
          overflow <= 1'b1;
        end else begin
          temp_data <= {temp_data[27:0], nibble};
          digit_cnt <= digit_cnt + 4'd1;
        end
      end else if (do_bksp) begin
        if (digit_cnt != '0) begin
          temp_data <= temp_data >> 4;
          digit_cnt <= digit_cnt - 4'd1;
        end
      end else if (do_esc) begin
        temp_data <= '0;
        digit_cnt <= '0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// Randomized check of key_entry (two configurations) against a digit-list reference model.
module tb_key_entry;

  logic        clk;
  logic        rst_n;
  logic [7:0]  scan_code;
  logic        scan_valid;

  logic [31:0] a_temp, a_reg, b_temp, b_reg;
  logic        a_enter, a_kp, a_ovf, b_enter, b_kp, b_ovf;
  logic [3:0]  a_cnt, b_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned kp_seen = 0;

  key_entry #(.MAX_DIGITS(8), .HEX_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .temp_data(a_temp), .reg_data(a_reg), .enter(a_enter), .key_pressed(a_kp),
    .digit_cnt(a_cnt), .overflow(a_ovf)
  );

  key_entry #(.MAX_DIGITS(3), .HEX_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .temp_data(b_temp), .reg_data(b_reg), .enter(b_enter), .key_pressed(b_kp),
    .digit_cnt(b_cnt), .overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: typed digits kept as an ordered list, prefix kept as two flags.
  logic [7:0]  key_tab [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };
  int          max_d [2] = '{8, 3};
  bit          hex_ok [2] = '{1'b1, 1'b0};
  int          digs [2][8];
  int          ndig [2];
  logic [31:0] m_reg [2];
  bit          m_ovf [2];
  bit          m_enter [2];
  bit          m_kp [2];
  bit          seen_brk, seen_ext;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] typed_value(input int i);
    logic [31:0] v = 0;
    for (int k = 0; k < ndig[i]; k++) v = v * 16 + 32'(digs[i][k]);
    return v;
  endfunction

  function automatic int key_value(input logic [7:0] c);
    for (int k = 0; k < 16; k++) if (key_tab[k] == c) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ndig[i] = 0; m_reg[i] = 0; m_ovf[i] = 0; m_enter[i] = 0; m_kp[i] = 0;
    end
    seen_brk = 0; seen_ext = 0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    bit make = 0, xenter = 0;
    int nv;
    if (seen_brk) begin
      seen_brk = 0; seen_ext = 0;
    end else if (c == 8'hF0) seen_brk = 1;
    else if (seen_ext) begin
      seen_ext = 0; xenter = (c == 8'h5A);
    end else if (c == 8'hE0) seen_ext = 1;
    else make = 1;

    for (int i = 0; i < 2; i++) begin
      if (xenter || (make && c == 8'h5A)) begin
        m_reg[i] = typed_value(i); ndig[i] = 0; m_ovf[i] = 0;
        m_enter[i] = 1; m_kp[i] = 1;
      end else if (make) begin
        nv = key_value(c);
        if (nv >= 0 && (hex_ok[i] || nv < 10)) begin
          m_kp[i] = 1;
          if (ndig[i] < max_d[i]) begin
            digs[i][ndig[i]] = nv; ndig[i]++;
          end else m_ovf[i] = 1;
        end else if (c == 8'h66) begin
          m_kp[i] = 1;
          if (ndig[i] > 0) ndig[i]--;
        end else if (c == 8'h76) begin
          m_kp[i] = 1; ndig[i] = 0; m_ovf[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("a_temp",  a_temp,  typed_value(0));
    chk("a_reg",   a_reg,   m_reg[0]);
    chk("a_cnt",   32'(a_cnt), 32'(ndig[0]));
    chk("a_ovf",   32'(a_ovf), 32'(m_ovf[0]));
    chk("a_enter", 32'(a_enter), 32'(m_enter[0]));
    chk("a_kp",    32'(a_kp), 32'(m_kp[0]));
    chk("b_temp",  b_temp,  typed_value(1));
    chk("b_reg",   b_reg,   m_reg[1]);
    chk("b_cnt",   32'(b_cnt), 32'(ndig[1]));
    chk("b_ovf",   32'(b_ovf), 32'(m_ovf[1]));
    chk("b_enter", 32'(b_enter), 32'(m_enter[1]));
    chk("b_kp",    32'(b_kp), 32'(m_kp[1]));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
  task automatic step(input bit v, input logic [7:0] c);
    scan_valid = v;
    scan_code  = c;
    for (int i = 0; i < 2; i++) begin m_enter[i] = 0; m_kp[i] = 0; end
    if (v) model_byte(c);
    @(negedge clk);
    if (a_kp) kp_seen++;
    check_all();
    scan_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    chk("rst_a_temp", a_temp, 32'h0);
    chk("rst_a_reg",  a_reg,  32'h0);
    chk("rst_a_misc", {a_cnt, a_ovf, a_enter, a_kp}, 32'h0);
    chk("rst_b_misc", {b_temp[3:0], b_cnt, b_ovf, b_enter, b_kp}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] seq30 [9] = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h5A, 8'hF0, 8'h5A};

  initial begin
    rst_n = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();
    step(1'b0, 8'h16);

    // Digit entry with releases, then commit.
    foreach (seq30[k]) send(seq30[k]);
    chk("seq30_reg", a_reg, 32'h0000_0012);
    step(1'b0, 8'h00);

    // Buffer fill and overflow.
    kp_seen = 0;
    repeat (9) send(8'h16);
    chk("fill_temp", a_temp, 32'h1111_1111);
    chk("fill_kp_pulses", 32'(kp_seen), 32'd9);
    send(8'h76);

    // Hex digits, backspace past empty.
    send(8'h1C); send(8'h32); send(8'h66);
    chk("bksp_temp", a_temp, 32'h0000_000A);
    send(8'h66); send(8'h66);
    chk("bksp_cnt", 32'(a_cnt), 32'd0);

    // Extended enter commits, extended release does nothing.
    send(8'h3D); send(8'hE0); send(8'h5A);
    chk("ext_reg", a_reg, 32'h0000_0007);
    send(8'h26); send(8'hE0); send(8'hF0); send(8'h5A);
    step(1'b0, 8'h00);

    // Hex keys dropped by the decimal-only instance; escape after digits.
    send(8'h1C); send(8'h45); send(8'h16); send(8'h76);

    // Reset mid-prefix discards the prefix.
    send(8'hF0);
    do_reset();
    send(8'h16);
    chk("rstprefix_temp", a_temp, 32'h0000_0001);

    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      logic [7:0]  c;
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2, 3: c = key_tab[$urandom_range(0, 15)];
        4:          c = 8'h66;
        5:          c = 8'h76;
        6:          c = 8'h5A;
        7:          c = 8'hF0;
        8:          c = 8'hE0;
        default:    c = 8'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, meaning the number of hex digits held (1..8).
REQ-002 SHALL have parameter HEX_EN, default 1, meaning A-F keys are accepted; when 0, A-F keys are ignored.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port scan_code, input, 8 bits: PS/2 set-2 byte from the frame receiver.
REQ-006 SHALL have port scan_valid, input, 1 bit: one-cycle strobe qualifying scan_code.
REQ-007 SHALL have port temp_data, output, 32 bits: digits typed so far, right-aligned nibbles, for the 7-seg tube.
REQ-008 SHALL have port reg_data, output, 32 bits: last committed value, consumed by the datapath keyboard input.
REQ-009 SHALL have port enter, output, 1 bit: one-cycle commit pulse, ORed into the datapath finish.
REQ-010 SHALL have port key_pressed, output, 1 bit: one-cycle pulse per accepted make code, for the LED.
REQ-011 SHALL have port digit_cnt, output, 4 bits: digits currently in temp_data.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a digit is rejected because the buffer is full.

Function
REQ-013 SHALL implement prefix FSM states IDLE, BRK, EXT, EXT_BRK, advancing only on scan_valid=1.
REQ-014 SHALL transition IDLE->BRK on 0xF0, IDLE->EXT on 0xE0, EXT->EXT_BRK on 0xF0, and BRK/EXT_BRK->IDLE on any byte (release, discarded).
REQ-015 SHALL treat a non-prefix byte in IDLE as a make code and act on it; in EXT, it SHALL act only on 0x5A (keypad enter), then return to IDLE.
REQ-016 SHALL map digits 0x45,16,1E,26,25,2E,36,3D,3E,46 to 0-9, and (HEX_EN=1) 0x1C,32,21,23,24,2B to A-F.
REQ-017 SHALL, on a digit with digit_cnt<MAX_DIGITS, set temp_data <= {temp_data[27:0],nibble} and increment digit_cnt.
REQ-018 SHALL, on a digit with digit_cnt==MAX_DIGITS, leave temp_data unchanged and set overflow.
REQ-019 SHALL, on 0x66 (backspace), shift temp_data right by 4 and decrement digit_cnt; at digit_cnt==0 it SHALL be a no-op.
REQ-020 SHALL, on 0x76 (escape), clear temp_data, digit_cnt and overflow.
REQ-021 SHALL, on 0x5A (enter, plain or extended), load reg_data<=temp_data, clear temp_data/digit_cnt/overflow, and pulse enter.
REQ-022 SHALL register all outputs, updating on the edge that samples scan_valid=1, so latency is one cycle; enter and key_pressed SHALL be high for exactly that following cycle.
REQ-023 SHALL assert key_pressed for every accepted make code (digit, backspace, escape, enter), including rejected digits; unknown codes SHALL be ignored with no pulse.
REQ-024 SHALL process typematic repeats as independent make codes.
REQ-025 SHALL ignore scan_code when scan_valid=0; strobes on consecutive cycles SHALL each be processed.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force the FSM to IDLE and temp_data, reg_data, digit_cnt, overflow, enter and key_pressed to 0.
REQ-027 SHALL, on reset mid-prefix (BRK/EXT), discard the prefix; the first byte after release SHALL be decoded from IDLE.

Structure
REQ-028 SHALL take the FSM state enum and scan-code constants (F0, E0, 5A, 66, 76, digit codes) from shared package key_pkg.
REQ-029 SHALL place the code-to-nibble lookup in combinational sub-module scan_decode (outputs nibble, is_digit, is_hex).

Verification
REQ-030 SHALL cover: bytes 16,F0,16,1E,F0,1E,5A,F0,5A -> temp_data 0x1 then 0x12; enter pulse; reg_data=0x00000012, temp_data=0.
REQ-031 SHALL cover: nine digit-1 makes -> temp_data=0x11111111, digit_cnt=8, overflow=1, 9 key_pressed pulses.
REQ-032 SHALL cover: 1C,32,66 -> temp_data 0xAB then 0xA; then 66,66 -> 0x0, digit_cnt=0, no underflow.
REQ-033 SHALL cover: E0,5A with temp_data=0x7 -> reg_data=0x7, enter pulse; E0,F0,5A -> no action.
REQ-034 SHALL cover: HEX_EN=0, bytes 1C -> ignored, no key_pressed; 76 after digits -> temp_data=0.
REQ-035 SHALL cover: rst_n low after F0 -> then 16 -> temp_data=0x1 (prefix discarded).
